// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard input stage.
// Holds set-2 scan-code constants, key index constants for the held-key
// vector, the receive FSM state type and small helper functions used by
// ps2_frame_rx and ps2_key_decoder.
package ps2_pkg;

    // Set-2 make codes for the keys the game listens to
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    // Extended (E0-prefixed) codes
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    // Prefix bytes
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Bit positions inside key_held
    localparam logic [3:0] KEY_A     = 4'd0;
    localparam logic [3:0] KEY_S     = 4'd1;
    localparam logic [3:0] KEY_D     = 4'd2;
    localparam logic [3:0] KEY_F     = 4'd3;
    localparam logic [3:0] KEY_W     = 4'd4;
    localparam logic [3:0] KEY_UP    = 4'd5;
    localparam logic [3:0] KEY_DOWN  = 4'd6;
    localparam logic [3:0] KEY_LEFT  = 4'd7;
    localparam logic [3:0] KEY_RIGHT = 4'd8;
    localparam logic [3:0] KEY_SPACE = 4'd9;
    localparam logic [3:0] KEY_ENTER = 4'd10;
    localparam int         NUM_KEYS  = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_hit_t;

    // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Map (extended flag, byte) to a held-key index; hit=0 for bytes we ignore
    function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = 4'd0;
        if (ext) begin
            case (code)
                SC_UP:    r.idx = KEY_UP;
                SC_DOWN:  r.idx = KEY_DOWN;
                SC_LEFT:  r.idx = KEY_LEFT;
                SC_RIGHT: r.idx = KEY_RIGHT;
                default:  r.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_A:     r.idx = KEY_A;
                SC_S:     r.idx = KEY_S;
                SC_D:     r.idx = KEY_D;
                SC_F:     r.idx = KEY_F;
                SC_W:     r.idx = KEY_W;
                SC_SPACE: r.idx = KEY_SPACE;
                SC_ENTER: r.idx = KEY_ENTER;
                default:  r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host byte receiver.
// Synchronises the raw PS/2 lines, glitch-filters the clock, detects
// filtered falling edges and assembles 11-bit frames (start, 8 data LSB
// first, odd parity, stop). A stalled frame is abandoned after
// TIMEOUT_CYCLES clocks without a falling edge.
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 lines
//   scan_valid        1-cycle pulse, scan_code holds a good byte
//   scan_code         last good byte (held between pulses)
//   frame_error       1-cycle pulse on bad start/parity/stop or timeout
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_error
);
    import ps2_pkg::*;

    localparam int                FILT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    logic              clk_meta_r, clk_sync_r;
    logic              dat_meta_r, dat_sync_r;
    logic              filt_r;
    logic [FILT_W-1:0] filt_cnt_r;
    logic              fe_r;

    rx_state_e         state_r, state_s;
    logic [2:0]        bitcnt_r, bitcnt_s;
    logic [7:0]        shift_r, shift_s;
    logic              parity_r, parity_s;
    logic [TMO_W-1:0]  tmo_r, tmo_s;
    logic              scan_valid_r, scan_valid_s;
    logic [7:0]        scan_code_r, scan_code_s;
    logic              frame_error_r, frame_error_s;

    // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= ps2_dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Clock glitch filter and registered falling-edge strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_r     <= 1'b1;
            filt_cnt_r <= '0;
            fe_r       <= 1'b0;
        end else if (clk_sync_r != filt_r) begin
            if (filt_cnt_r == FILT_LAST) begin
                // Enough consecutive disagreeing samples: accept the new level
                filt_r     <= clk_sync_r;
                filt_cnt_r <= '0;
                fe_r       <= ~clk_sync_r;
            end else begin
                filt_cnt_r <= filt_cnt_r + FILT_W'(1);
                fe_r       <= 1'b0;
            end
        end else begin
            filt_cnt_r <= '0;
            fe_r       <= 1'b0;
        end
    end

    // Frame FSM next-state, shift, timeout and output decisions
    always_comb begin
        state_s       = state_r;
        bitcnt_s      = bitcnt_r;
        shift_s       = shift_r;
        parity_s      = parity_r;
        tmo_s         = tmo_r;
        scan_valid_s  = 1'b0;
        scan_code_s   = scan_code_r;
        frame_error_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // A high start bit is treated as line noise, not an error
                if (fe_r && !dat_sync_r) begin
                    state_s  = ST_DATA;
                    bitcnt_s = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fe_r) begin
                    shift_s = {dat_sync_r, shift_r[7:1]};
                    if (bitcnt_r == 3'd7) begin
                        state_s = ST_PARITY;
                    end else begin
                        bitcnt_s = bitcnt_r + 3'd1;
                    end
                end else begin
                    shift_s = shift_r;
                end
            end
            ST_PARITY: begin
                if (fe_r) begin
                    parity_s = dat_sync_r;
                    state_s  = ST_STOP;
                end else begin
                    parity_s = parity_r;
                end
            end
            ST_STOP: begin
                if (fe_r) begin
                    state_s = ST_IDLE;
                    if (dat_sync_r && odd_parity_ok(shift_r, parity_r)) begin
                        scan_valid_s = 1'b1;
                        scan_code_s  = shift_r;
                    end else begin
                        frame_error_s = 1'b1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Mid-frame watchdog: any falling edge restarts it
        if (state_r != ST_IDLE) begin
            if (fe_r) begin
                tmo_s = '0;
            end else if (tmo_r == TMO_LAST) begin
                tmo_s         = '0;
                state_s       = ST_IDLE;
                frame_error_s = 1'b1;
            end else begin
                tmo_s = tmo_r + TMO_W'(1);
            end
        end else begin
            tmo_s = '0;
        end
    end

    // Frame FSM state and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            bitcnt_r      <= 3'd0;
            shift_r       <= 8'h00;
            parity_r      <= 1'b0;
            tmo_r         <= '0;
            scan_valid_r  <= 1'b0;
            scan_code_r   <= 8'h00;
            frame_error_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            bitcnt_r      <= bitcnt_s;
            shift_r       <= shift_s;
            parity_r      <= parity_s;
            tmo_r         <= tmo_s;
            scan_valid_r  <= scan_valid_s;
            scan_code_r   <= scan_code_s;
            frame_error_r <= frame_error_s;
        end
    end

    assign scan_valid  = scan_valid_r;
    assign scan_code   = scan_code_r;
    assign frame_error = frame_error_r;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard front end for the rhythm game.
// Receives set-2 scan codes through ps2_frame_rx, tracks the F0 (break)
// and E0 (extended) prefixes, keeps a held level per game key and emits
// one-cycle column-press pulses on the rising edge of a/s/d/f.
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 lines (receive only)
//   key_held[10:0]    {enter,space,right,left,down,up,w,f,d,s,a}
//   col_press[3:0]    1-cycle pulse on 0->1 of {f,d,s,a}
//   scan_valid        1-cycle pulse, scan_code holds a good byte
//   scan_code[7:0]    last good byte
//   frame_error       1-cycle pulse on a rejected or timed-out frame
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [10:0] key_held,
    output logic [3:0]  col_press,
    output logic        scan_valid,
    output logic [7:0]  scan_code,
    output logic        frame_error
);
    import ps2_pkg::*;

    logic                rx_valid_s;
    logic [7:0]          rx_code_s;
    logic                rx_error_s;

    logic                brk_r, brk_s;
    logic                ext_r, ext_s;
    logic [NUM_KEYS-1:0] held_r, held_s;
    logic [3:0]          col_press_r;
    key_hit_t            hit_s;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .scan_valid  (rx_valid_s),
        .scan_code   (rx_code_s),
        .frame_error (rx_error_s)
    );

    // Prefix tracking and held-key update for the byte just received
    always_comb begin
        held_s = held_r;
        brk_s  = brk_r;
        ext_s  = ext_r;
        hit_s  = key_lookup(ext_r, rx_code_s);
        if (rx_error_s) begin
            // A lost frame may have been the rest of a prefixed code
            brk_s = 1'b0;
            ext_s = 1'b0;
        end else if (rx_valid_s) begin
            if (rx_code_s == SC_BREAK) begin
                brk_s = 1'b1;
            end else if (rx_code_s == SC_EXT) begin
                ext_s = 1'b1;
            end else begin
                if (hit_s.hit) begin
                    held_s[hit_s.idx] = ~brk_r;
                end else begin
                    held_s = held_r;
                end
                brk_s = 1'b0;
                ext_s = 1'b0;
            end
        end else begin
            held_s = held_r;
        end
    end

    // Decode registers; press pulses come from the held transition itself
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            brk_r       <= 1'b0;
            ext_r       <= 1'b0;
            held_r      <= '0;
            col_press_r <= 4'b0000;
        end else begin
            brk_r       <= brk_s;
            ext_r       <= ext_s;
            held_r      <= held_s;
            col_press_r <= held_s[3:0] & ~held_r[3:0];
        end
    end

    assign key_held    = held_r;
    assign col_press   = col_press_r;
    assign scan_valid  = rx_valid_s;
    assign scan_code   = rx_code_s;
    assign frame_error = rx_error_s;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench for ps2_key_decoder.
// The driver sends PS/2 frames and pushes the expected bytes, held-key
// vectors, press pulses and errors into queues; a monitor pops and
// compares whenever the DUT presents one of those outputs.
module tb_ps2_key_decoder;

    localparam int TIMEOUT_CYCLES = 10000;
    localparam int SLOW_HALF      = 2000;   // 12.5 kHz PS/2 clock
    localparam int FAST_HALF      = 30;

    logic        clock;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [10:0] key_held;
    logic [3:0]  col_press;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic        frame_error;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_scan[$];
    logic [10:0] exp_held[$];
    logic [3:0]  exp_press[$];
    int          exp_err[$];

    ps2_key_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .key_held    (key_held),
        .col_press   (col_press),
        .scan_valid  (scan_valid),
        .scan_code   (scan_code),
        .frame_error (frame_error)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One PS/2 bit: data set while clock high, device pulls clock low
    task automatic send_bit(input logic b, input int half, input bit glitch);
        ps2_dat = b;
        repeat (half / 2) @(posedge clock);
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (2) @(posedge clock);
            ps2_clk = 1'b1;
        end
        repeat (half - half / 2) @(posedge clock);
        ps2_clk = 1'b0;
        repeat (half / 2) @(posedge clock);
        if (glitch) begin
            ps2_clk = 1'b1;
            repeat (2) @(posedge clock);
            ps2_clk = 1'b0;
        end
        repeat (half - half / 2) @(posedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int half, input bit bad_par,
                              input bit glitch, input int nbits);
        logic [10:0] f;
        logic        p;
        p = (~^b) ^ bad_par;
        f = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], half, glitch);
        ps2_dat = 1'b1;
        repeat (150) @(posedge clock);
    endtask

    task automatic good(input logic [7:0] b);
        exp_scan.push_back(b);
        send_frame(b, FAST_HALF, 1'b0, 1'b0, 11);
    endtask

    // Monitor: compare each DUT event against the head of its queue
    initial begin
        logic [10:0] held_prev;
        logic        sv_prev;
        held_prev = 11'h000;
        sv_prev   = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (scan_valid) begin
                    if (exp_scan.size() == 0) check("scan_unexpected", 32'(scan_code), 32'hFFFF);
                    else check("scan_code", 32'(scan_code), 32'(exp_scan.pop_front()));
                end
                if (frame_error) begin
                    if (exp_err.size() == 0) check("error_unexpected", 32'd1, 32'd0);
                    else check("frame_error", 32'd1, 32'(exp_err.pop_front()));
                end
                if (key_held != held_prev) begin
                    check("held_latency", 32'(sv_prev), 32'd1);
                    if (exp_held.size() == 0) check("held_unexpected", 32'(key_held), 32'(held_prev));
                    else check("key_held", 32'(key_held), 32'(exp_held.pop_front()));
                end
                if (col_press != 4'b0000) begin
                    check("press_latency", 32'(sv_prev), 32'd1);
                    if (exp_press.size() == 0) check("press_unexpected", 32'(col_press), 32'd0);
                    else check("col_press", 32'(col_press), 32'(exp_press.pop_front()));
                end
            end
            held_prev = key_held;
            sv_prev   = scan_valid;
        end
    end

    initial begin
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("reset_held", 32'(key_held), 32'd0);
        check("reset_press", 32'(col_press), 32'd0);
        check("reset_valid", 32'(scan_valid), 32'd0);
        check("reset_code", 32'(scan_code), 32'd0);
        check("reset_error", 32'(frame_error), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(posedge clock);

        // Single make code at the real PS/2 rate
        exp_scan.push_back(8'h1C);
        exp_held.push_back(11'h001);
        exp_press.push_back(4'b0001);
        send_frame(8'h1C, SLOW_HALF, 1'b0, 1'b0, 11);

        // Typematic repeats then break: no more pulses, a released
        good(8'h1C);
        good(8'h1C);
        exp_held.push_back(11'h000);
        good(8'hF0);
        good(8'h1C);

        // Extended up, then f, then extended break of up
        good(8'hE0);
        exp_held.push_back(11'h020);
        good(8'h75);
        exp_held.push_back(11'h028);
        exp_press.push_back(4'b1000);
        good(8'h2B);
        good(8'hE0);
        good(8'hF0);
        exp_held.push_back(11'h008);
        good(8'h75);

        // Bad parity is rejected, the next good d is accepted
        exp_err.push_back(1);
        send_frame(8'h23, FAST_HALF, 1'b1, 1'b0, 11);
        exp_held.push_back(11'h00C);
        exp_press.push_back(4'b0100);
        good(8'h23);

        // Stalled frame: start plus 3 data bits, then a silent clock
        exp_err.push_back(1);
        send_frame(8'h1B, FAST_HALF, 1'b0, 1'b0, 4);
        repeat (TIMEOUT_CYCLES + 100) @(posedge clock);
        exp_held.push_back(11'h00E);
        exp_press.push_back(4'b0010);
        good(8'h1B);

        // Glitches on the PS/2 clock must not add bits
        exp_scan.push_back(8'h1C);
        exp_held.push_back(11'h00F);
        exp_press.push_back(4'b0001);
        send_frame(8'h1C, FAST_HALF, 1'b0, 1'b1, 11);

        // Reset in the middle of a frame clears everything at once
        for (int i = 0; i < 3; i++) send_bit(i == 0 ? 1'b0 : 1'b1, FAST_HALF, 1'b0);
        ps2_clk = 1'b0;
        repeat (5) @(posedge clock);
        reset = 1'b1;
        #1;
        check("midreset_held", 32'(key_held), 32'd0);
        check("midreset_press", 32'(col_press), 32'd0);
        check("midreset_valid", 32'(scan_valid), 32'd0);
        check("midreset_code", 32'(scan_code), 32'd0);
        check("midreset_error", 32'(frame_error), 32'd0);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(posedge clock);

        // Receiver restarts cleanly after reset
        exp_held.push_back(11'h001);
        exp_press.push_back(4'b0001);
        good(8'h1C);

        repeat (200) @(posedge clock);
        check("left_scan", 32'(exp_scan.size()), 32'd0);
        check("left_held", 32'(exp_held.size()), 32'd0);
        check("left_press", 32'(exp_press.size()), 32'd0);
        check("left_error", 32'(exp_err.size()), 32'd0);
        check("final_held", 32'(key_held), 32'h001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
